// File: rtl/sdram_bist.sv
// SDRAM built-in self-test master: write/read/compare sweep
// over a word window with a true and a complemented pattern.
module sdram_bist #(
    parameter logic [20:0] FIRST_ADR = 21'h000000,
    parameter logic [20:0] LAST_ADR  = 21'h1FFFFF,
    parameter logic [15:0] SEED      = 16'hA5C3,
    parameter int          TIMEOUT   = 1023
) (
    input  logic        clk_p,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        sdram_ready,
    output logic        sdram_stb,
    output logic        sdram_we,
    output logic [1:0]  sdram_sel,
    output logic [20:0] sdram_adr,
    output logic [15:0] sdram_out,
    input  logic [15:0] sdram_dat,
    input  logic        sdram_ack,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic        timeout,
    output logic [20:0] err_adr,
    output logic [15:0] err_exp,
    output logic [15:0] err_got
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAITRDY, S_WR, S_WR_GAP,
        S_RD, S_RD_GAP, S_DONE, S_FAIL
    } state_t;

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

    function automatic logic [15:0] pat(
        input logic [20:0] a,
        input logic        inv
    );
        logic [15:0] p;
        p = a[15:0] ^ {11'b0, a[20:16]} ^ SEED;
        return inv ? ~p : p;
    endfunction

    state_t      state, state_n;
    logic [20:0] adr, adr_n;
    logic        pass, pass_n;
    logic [15:0] tcnt, tcnt_n;

    logic        stb_n, we_n;
    logic [20:0] sadr_n;
    logic [15:0] out_n;
    logic        busy_n, done_n, fail_n, to_n;
    logic [20:0] err_adr_n;
    logic [15:0] err_exp_n, err_got_n;

    logic        ack_v;
    logic [15:0] exp_d;
    logic [15:0] tcnt_inc;

    assign sdram_sel = 2'b11;

    // State, sweep counters and all registered bus/status outputs
    always_ff @(posedge clk_p or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            adr       <= FIRST_ADR;
            pass      <= 1'b0;
            tcnt      <= '0;
            sdram_stb <= 1'b0;
            sdram_we  <= 1'b0;
            sdram_adr <= '0;
            sdram_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            err_adr   <= '0;
            err_exp   <= '0;
            err_got   <= '0;
        end else begin
            state     <= state_n;
            adr       <= adr_n;
            pass      <= pass_n;
            tcnt      <= tcnt_n;
            sdram_stb <= stb_n;
            sdram_we  <= we_n;
            sdram_adr <= sadr_n;
            sdram_out <= out_n;
            busy      <= busy_n;
            done      <= done_n;
            fail      <= fail_n;
            timeout   <= to_n;
            err_adr   <= err_adr_n;
            err_exp   <= err_exp_n;
            err_got   <= err_got_n;
        end
    end

    // Next-state, sweep sequencing, compare and timeout detection
    always_comb begin
        state_n   = state;
        adr_n     = adr;
        pass_n    = pass;
        tcnt_n    = tcnt;
        we_n      = sdram_we;
        sadr_n    = sdram_adr;
        out_n     = sdram_out;
        busy_n    = busy;
        done_n    = done;
        fail_n    = fail;
        to_n      = timeout;
        err_adr_n = err_adr;
        err_exp_n = err_exp;
        err_got_n = err_got;
        ack_v     = sdram_stb & sdram_ack;
        exp_d     = pat(adr, pass);
        tcnt_inc  = tcnt + 16'd1;

        if (abort) begin
            state_n = S_IDLE;
            busy_n  = 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        done_n    = 1'b0;
                        fail_n    = 1'b0;
                        to_n      = 1'b0;
                        err_adr_n = '0;
                        err_exp_n = '0;
                        err_got_n = '0;
                        busy_n    = 1'b1;
                        pass_n    = 1'b0;
                        adr_n     = FIRST_ADR;
                        state_n   = S_WAITRDY;
                    end
                end
                S_WAITRDY: begin
                    if (sdram_ready) begin
                        tcnt_n  = '0;
                        state_n = S_WR;
                    end
                end
                S_WR, S_RD: begin
                    if (ack_v) begin
                        if (state == S_WR) begin
                            state_n = S_WR_GAP;
                        end else if (sdram_dat != exp_d) begin
                            err_adr_n = adr;
                            err_exp_n = exp_d;
                            err_got_n = sdram_dat;
                            state_n   = S_FAIL;
                        end else begin
                            state_n = S_RD_GAP;
                        end
                    end else if (tcnt_inc == TO_LIM) begin
                        to_n      = 1'b1;
                        err_adr_n = adr;
                        err_exp_n = exp_d;
                        err_got_n = '0;
                        state_n   = S_FAIL;
                    end else begin
                        tcnt_n = tcnt_inc;
                    end
                end
                S_WR_GAP: begin
                    tcnt_n = '0;
                    if (adr == LAST_ADR) begin
                        adr_n   = FIRST_ADR;
                        state_n = S_RD;
                    end else begin
                        adr_n   = adr + 21'd1;
                        state_n = S_WR;
                    end
                end
                S_RD_GAP: begin
                    tcnt_n = '0;
                    if (adr != LAST_ADR) begin
                        adr_n   = adr + 21'd1;
                        state_n = S_RD;
                    end else if (!pass) begin
                        pass_n  = 1'b1;
                        adr_n   = FIRST_ADR;
                        state_n = S_WR;
                    end else begin
                        state_n = S_DONE;
                    end
                end
                S_DONE: begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end
                S_FAIL: begin
                    busy_n  = 1'b0;
                    fail_n  = 1'b1;
                    state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end

        // Bus fields load on access entry and hold until the access ends
        stb_n = (state_n == S_WR) || (state_n == S_RD);
        if (stb_n) begin
            we_n   = (state_n == S_WR);
            sadr_n = adr_n;
            if (state_n == S_WR) begin
                out_n = pat(adr_n, pass_n);
            end
        end
    end

endmodule

// File: tb/tb_sdram_bist.sv
// Directed self-checking bench for sdram_bist: sweep, data
// fault, ack timeout, ready gating, abort/reset, single word.
module tb_sdram_bist;

    logic        clk_p = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start1 = 1'b0;
    logic        abort = 1'b0;
    logic        sdram_ready = 1'b0;

    logic        stb0, we0;
    logic [1:0]  sel0;
    logic [20:0] adr0;
    logic [15:0] out0;
    logic [15:0] dat0 = '0;
    logic        ack0 = 1'b0;
    logic        busy0, done0, fail0, to0;
    logic [20:0] ea0;
    logic [15:0] ee0, eg0;

    logic        stb1, we1;
    logic [1:0]  sel1;
    logic [20:0] adr1;
    logic [15:0] out1;
    logic [15:0] dat1 = '0;
    logic        ack1 = 1'b0;
    logic        busy1, done1, fail1, to1;
    logic [20:0] ea1;
    logic [15:0] ee1, eg1;

    int errors = 0;
    int checks = 0;

    always #5 clk_p = ~clk_p;

    sdram_bist #(
        .FIRST_ADR(21'h000000),
        .LAST_ADR (21'h000003),
        .SEED     (16'hA5C3),
        .TIMEOUT  (8)
    ) u0 (
        .clk_p(clk_p), .reset(reset), .start(start),
        .abort(abort), .sdram_ready(sdram_ready),
        .sdram_stb(stb0), .sdram_we(we0), .sdram_sel(sel0),
        .sdram_adr(adr0), .sdram_out(out0),
        .sdram_dat(dat0), .sdram_ack(ack0),
        .busy(busy0), .done(done0), .fail(fail0),
        .timeout(to0), .err_adr(ea0), .err_exp(ee0),
        .err_got(eg0)
    );

    sdram_bist #(
        .FIRST_ADR(21'h1FFFFF),
        .LAST_ADR (21'h1FFFFF)
    ) u1 (
        .clk_p(clk_p), .reset(reset), .start(start1),
        .abort(abort), .sdram_ready(sdram_ready),
        .sdram_stb(stb1), .sdram_we(we1), .sdram_sel(sel1),
        .sdram_adr(adr1), .sdram_out(out1),
        .sdram_dat(dat1), .sdram_ack(ack1),
        .busy(busy1), .done(done1), .fail(fail1),
        .timeout(to1), .err_adr(ea1), .err_exp(ee1),
        .err_got(eg1)
    );

    // Memory model for u0: ack two cycles after stb, optional fault
    logic [15:0] mem0 [4];
    logic        noack = 1'b0;
    logic        fault = 1'b0;
    int          wcnt0 = 0;
    logic        prev0 = 1'b0;
    int          n0 = 0;
    int          hi0 = 0;
    int          acks0 = 0;
    logic        lwe0  [256];
    logic [20:0] ladr0 [256];
    logic [15:0] ldat0 [256];

    always @(posedge clk_p) begin
        prev0 <= stb0;
        if (stb0) hi0 <= hi0 + 1;
        if (stb0 && !prev0) begin
            if (n0 < 256) begin
                lwe0[n0]  <= we0;
                ladr0[n0] <= adr0;
                ldat0[n0] <= out0;
            end
            n0 <= n0 + 1;
        end
        if (stb0 && !ack0 && !noack) begin
            if (wcnt0 == 1) begin
                ack0  <= 1'b1;
                wcnt0 <= 0;
                acks0 <= acks0 + 1;
                if (we0) mem0[adr0[1:0]] <= out0;
                else dat0 <= mem0[adr0[1:0]] |
                    ((fault && adr0 == 21'd2) ? 16'h0010 : 16'h0000);
            end else begin
                wcnt0 <= wcnt0 + 1;
            end
        end else begin
            ack0  <= 1'b0;
            wcnt0 <= 0;
        end
    end

    // Memory model for u1: single word, ack one cycle after stb
    logic [15:0] mem1 = '0;
    logic        prev1 = 1'b0;
    int          n1 = 0;
    logic        lwe1  [8];
    logic [20:0] ladr1 [8];
    logic [15:0] ldat1 [8];

    always @(posedge clk_p) begin
        prev1 <= stb1;
        if (stb1 && !prev1) begin
            if (n1 < 8) begin
                lwe1[n1]  <= we1;
                ladr1[n1] <= adr1;
                ldat1[n1] <= out1;
            end
            n1 <= n1 + 1;
        end
        if (stb1 && !ack1) begin
            ack1 <= 1'b1;
            if (we1) mem1 <= out1;
            else dat1 <= mem1;
        end else begin
            ack1 <= 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_p);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk_p);
        start = 1'b0;
    endtask

    task automatic wait_end(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk_p);
            if (done0 || fail0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        checks++;
        if ({stb0, we0} !== 2'b00) begin
            errors++;
            $display("FAIL reset_bus got=%b exp=00", {stb0, we0});
        end
        checks++;
        if ({busy0, done0, fail0, to0} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {busy0, done0, fail0, to0});
        end
        checks++;
        if ({adr0, out0} !== 37'd0) begin
            errors++;
            $display("FAIL reset_adr_out got=%h/%h exp=0/0", adr0, out0);
        end
        checks++;
        if ({ea0, ee0, eg0} !== 53'd0) begin
            errors++;
            $display("FAIL reset_err got=%h/%h/%h exp=0", ea0, ee0, eg0);
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_sweep();
        logic [15:0] wexp [8];
        bit ok;
        int b, a;
        wexp = '{16'hA5C3, 16'hA5C2, 16'hA5C1, 16'hA5C0,
                 16'h5A3C, 16'h5A3D, 16'h5A3E, 16'h5A3F};
        b = n0;
        a = acks0;
        sdram_ready = 1'b1;
        pulse_start();
        checks++;
        if (sel0 !== 2'b11) begin
            errors++;
            $display("FAIL sweep_sel got=%b exp=11", sel0);
        end
        wait_end(400, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL sweep_end got=timeout exp=done");
        end
        checks++;
        if ({done0, fail0, busy0} !== 3'b100) begin
            errors++;
            $display("FAIL sweep_flags got=%b exp=100",
                     {done0, fail0, busy0});
        end
        checks++;
        if (n0 - b !== 16) begin
            errors++;
            $display("FAIL sweep_count got=%0d exp=16", n0 - b);
        end
        checks++;
        if (acks0 - a !== 16) begin
            errors++;
            $display("FAIL sweep_gaps got=%0d acks exp=16", acks0 - a);
        end
        for (int k = 0; k < 16; k++) begin
            logic        ew;
            logic [20:0] ea;
            int          pi;
            ew = (k % 8) < 4;
            ea = 21'(k % 4);
            pi = (k / 8) * 4 + (k % 4);
            checks++;
            if (lwe0[b+k] !== ew || ladr0[b+k] !== ea ||
                (ew && ldat0[b+k] !== wexp[pi])) begin
                errors++;
                $display("FAIL sweep_tx%0d got=%b/%h/%h exp=%b/%h/%h",
                         k, lwe0[b+k], ladr0[b+k], ldat0[b+k],
                         ew, ea, wexp[pi]);
            end
        end
        tick(2);
    endtask

    task automatic test_fail();
        bit ok;
        int b;
        fault = 1'b1;
        b = n0;
        pulse_start();
        wait_end(400, ok);
        checks++;
        if (!ok || {done0, fail0, to0} !== 3'b010) begin
            errors++;
            $display("FAIL fault_flags got=%b exp=010",
                     {done0, fail0, to0});
        end
        checks++;
        if (ea0 !== 21'd2 || ee0 !== 16'hA5C1 || eg0 !== 16'hA5D1) begin
            errors++;
            $display("FAIL fault_err got=%h/%h/%h exp=2/a5c1/a5d1",
                     ea0, ee0, eg0);
        end
        tick(20);
        checks++;
        if (n0 - b !== 7 || stb0 !== 1'b0) begin
            errors++;
            $display("FAIL fault_stop got=%0d/%b exp=7/0", n0 - b, stb0);
        end
        fault = 1'b0;
    endtask

    task automatic test_timeout();
        bit ok;
        int b;
        noack = 1'b1;
        b = hi0;
        pulse_start();
        wait_end(200, ok);
        checks++;
        if (!ok || {done0, fail0, to0} !== 3'b011) begin
            errors++;
            $display("FAIL to_flags got=%b exp=011", {done0, fail0, to0});
        end
        checks++;
        if (hi0 - b !== 8) begin
            errors++;
            $display("FAIL to_stb_cycles got=%0d exp=8", hi0 - b);
        end
        checks++;
        if (ea0 !== 21'd0 || ee0 !== 16'hA5C3 || eg0 !== 16'h0000 ||
            stb0 !== 1'b0) begin
            errors++;
            $display("FAIL to_err got=%h/%h/%h/%b exp=0/a5c3/0/0",
                     ea0, ee0, eg0, stb0);
        end
        noack = 1'b0;
        tick(2);
    endtask

    task automatic test_ready();
        bit ok;
        int bad;
        bit seen;
        sdram_ready = 1'b0;
        pulse_start();
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_p);
            if (busy0 !== 1'b1 || stb0 !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL ready_hold got=%0d bad cycles exp=0", bad);
        end
        sdram_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_p);
            if (stb0 && we0) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ready_rise got=no_stb exp=stb");
        end
        wait_end(400, ok);
        checks++;
        if (!ok || done0 !== 1'b1) begin
            errors++;
            $display("FAIL ready_done got=%b exp=1", done0);
        end
    endtask

    task automatic test_abort();
        bit ok;
        bit seen;
        int b;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_p);
            if (stb0 && !we0) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL abort_find got=no_read exp=read");
        end
        abort = 1'b1;
        @(negedge clk_p);
        checks++;
        if ({stb0, busy0, done0, fail0} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_stop got=%b exp=0000",
                     {stb0, busy0, done0, fail0});
        end
        abort = 1'b0;
        tick(3);
        b = n0;
        pulse_start();
        wait_end(400, ok);
        checks++;
        if (!ok || done0 !== 1'b1 || n0 - b !== 16 ||
            lwe0[b] !== 1'b1 || ladr0[b] !== 21'd0) begin
            errors++;
            $display("FAIL abort_rerun got=%b/%0d/%b/%h exp=1/16/1/0",
                     done0, n0 - b, lwe0[b], ladr0[b]);
        end
        tick(2);
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_p);
            if (stb0 && we0) begin
                seen = 1'b1;
                break;
            end
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (!seen || {stb0, we0, adr0, out0} !== 39'd0 ||
            {busy0, done0, fail0, to0} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset got=%b/%b/%h/%h/%b exp=0",
                     stb0, we0, adr0, out0,
                     {busy0, done0, fail0, to0});
        end
        @(negedge clk_p);
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_single();
        bit ok;
        logic [15:0] wexp [4];
        logic        wwe  [4];
        wexp = '{16'h5A23, 16'h0000, 16'hA5DC, 16'h0000};
        wwe  = '{1'b1, 1'b0, 1'b1, 1'b0};
        start1 = 1'b1;
        @(negedge clk_p);
        start1 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_p);
            if (done1 || fail1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || {done1, fail1} !== 2'b10 || sel1 !== 2'b11) begin
            errors++;
            $display("FAIL single_flags got=%b/%b exp=10/11",
                     {done1, fail1}, sel1);
        end
        checks++;
        if (n1 !== 4) begin
            errors++;
            $display("FAIL single_count got=%0d exp=4", n1);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ladr1[k] !== 21'h1FFFFF || lwe1[k] !== wwe[k] ||
                (wwe[k] && ldat1[k] !== wexp[k])) begin
                errors++;
                $display("FAIL single_tx%0d got=%b/%h/%h exp=%b/1fffff/%h",
                         k, lwe1[k], ladr1[k], ldat1[k], wwe[k], wexp[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_fail();
        test_timeout();
        test_ready();
        test_abort();
        test_single();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=hang exp=finish");
        $fatal(1);
    end

endmodule
